// File: rtl/hamming_pkg.sv
// Shared constants and types for the serial Hamming (7,4) datapath.
package hamming_pkg;

    localparam int CODE_LEN = 7;
    localparam int POS_W    = 3;

    // Bit position within a codeword frame (1..CODE_LEN; 0 reserved as "none").
    typedef logic [POS_W-1:0] pos_t;

endpackage : hamming_pkg

// File: rtl/frame_pos_counter.sv
// Frame position counter: tracks the 1-based bit position inside a serial
// codeword frame and wraps from FRAME_LEN back to 1.
module frame_pos_counter
    import hamming_pkg::*;
#(
    parameter int FRAME_LEN = CODE_LEN,
    parameter int POS_W     = hamming_pkg::POS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [POS_W-1:0] pos,
    output logic             frame_start
);

    localparam logic [POS_W-1:0] POS_FIRST = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_LEN);

    logic [POS_W-1:0] r_pos;

    // Advance once per accepted bit; the last position folds back to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= POS_FIRST;
        end else if (adv) begin
            r_pos <= (r_pos == POS_LAST) ? POS_FIRST : r_pos + POS_W'(1);
        end
    end

    assign pos         = r_pos;
    assign frame_start = (r_pos == POS_FIRST);

endmodule : frame_pos_counter

// File: rtl/error_inject_serial.sv
// Serial single-bit error injector: forwards each accepted codeword bit and
// inverts the one bit per frame whose position equals the selected error
// position. Position 0 (or any value beyond the frame) disables injection.
module error_inject_serial
    import hamming_pkg::*;
#(
    parameter int FRAME_LEN = CODE_LEN,
    parameter int POS_W     = hamming_pkg::POS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             strobe_in,
    input  logic [POS_W-1:0] error_pos,
    output logic             d_out,
    output logic             strobe_out
);

    logic             r_strobe_q;
    logic [POS_W-1:0] r_err_lat;
    logic             r_d_out;
    logic             r_strobe_out;

    logic             w_accept;
    logic [POS_W-1:0] w_pos;
    logic             w_frame_start;
    logic [POS_W-1:0] w_active_err;
    logic             w_hit;

    // Rising edge of the strobe accepts exactly one bit, however long it is held.
    assign w_accept = strobe_in & ~r_strobe_q;

    frame_pos_counter #(
        .FRAME_LEN (FRAME_LEN),
        .POS_W     (POS_W)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .adv         (w_accept),
        .pos         (w_pos),
        .frame_start (w_frame_start)
    );

    // The first bit of a frame has no latched value yet, so it compares
    // against the live input; the rest of the frame uses the latch.
    // Since pos never leaves 1..FRAME_LEN, 0 and out-of-range values never hit.
    assign w_active_err = w_frame_start ? error_pos : r_err_lat;
    assign w_hit        = (w_pos == w_active_err);

    // Strobe history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_q <= 1'b0;
        end else begin
            r_strobe_q <= strobe_in;
        end
    end

    // Capture the error position once per frame, on its first accepted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_lat <= '0;
        end else if (w_accept && w_frame_start) begin
            r_err_lat <= error_pos;
        end
    end

    // Registered output: forward (possibly inverted) bit with a one-clk strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_out      <= 1'b0;
            r_strobe_out <= 1'b0;
        end else if (w_accept) begin
            r_d_out      <= d_in ^ w_hit;
            r_strobe_out <= 1'b1;
        end else begin
            r_strobe_out <= 1'b0;
        end
    end

    assign d_out      = r_d_out;
    assign strobe_out = r_strobe_out;

endmodule : error_inject_serial

// File: tb/tb_error_inject_serial.sv
// Self-checking bench for error_inject_serial: directed scenarios plus
// randomized traffic checked against a frame-level reference model.
module tb_error_inject_serial;

    localparam int FL = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d_in = 1'b0;
    logic       strobe_in = 1'b0;
    logic [2:0] error_pos = 3'd0;
    logic       d_out, strobe_out;
    logic       d_out5, strobe_out5;

    int checks = 0;
    int errors = 0;

    // Reference model state: bits accepted since reset and the frame's error position.
    int m_cnt = 0;
    int m_err = 0;

    // Per-bit observations from the most recent send_bit.
    logic obs_d, obs_s, obs_s_after, obs_d5, obs_s5, exp_d;

    // Per-frame observations from send_frame.
    logic [0:6] fd, fexp, fok;

    always #5 clk = ~clk;

    error_inject_serial #(.FRAME_LEN(7), .POS_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .strobe_in  (strobe_in),
        .error_pos  (error_pos),
        .d_out      (d_out),
        .strobe_out (strobe_out)
    );

    error_inject_serial #(.FRAME_LEN(5), .POS_W(3)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_in       (d_in),
        .strobe_in  (strobe_in),
        .error_pos  (error_pos),
        .d_out      (d_out5),
        .strobe_out (strobe_out5)
    );

    // Model: bit k after reset sits at position (k mod FL)+1; the error position
    // is taken at position 1 and held for the frame.
    task automatic model_step(input logic d, input int ep, output logic e);
        int p;
        p = (m_cnt % FL) + 1;
        if (p == 1) m_err = ep;
        e = d ^ (p == m_err);
        m_cnt++;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_err = 0;
    endtask

    // One strobe pulse carrying bit d, then 'low' clocks with strobe low.
    task automatic send_bit(input logic d, input int low);
        @(negedge clk);
        d_in = d;
        strobe_in = 1'b1;
        @(posedge clk);
        #1;
        obs_d  = d_out;
        obs_s  = strobe_out;
        obs_d5 = d_out5;
        obs_s5 = strobe_out5;
        @(negedge clk);
        strobe_in = 1'b0;
        d_in = 1'($urandom_range(0, 1));
        repeat (low) @(posedge clk);
        #1;
        obs_s_after = strobe_out;
        model_step(d, int'(error_pos), exp_d);
    endtask

    task automatic send_frame(input logic [0:6] f);
        for (int i = 0; i < 7; i++) begin
            send_bit(f[i], 1);
            fd[i]   = obs_d;
            fexp[i] = exp_d;
            fok[i]  = obs_s & ~obs_s_after;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        // Reset held from time zero.
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({d_out, strobe_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_init got d_out=%b strobe_out=%b exp 0 0", d_out, strobe_out);
        end
        // Strobe already high at release is accepted on the first edge; error_pos=1 inverts it.
        error_pos = 3'd1;
        d_in = 1'b1;
        strobe_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        model_step(1'b1, 1, exp_d);
        checks++;
        if ({strobe_out, d_out} !== {1'b1, exp_d}) begin
            errors++;
            $display("FAIL reset_release_pos1 got s=%b d=%b exp s=1 d=%b", strobe_out, d_out, exp_d);
        end
        @(negedge clk);
        strobe_in = 1'b0;
        // Two more bits, the last a 1 so d_out is high, then reset while strobe_out is high.
        send_bit(1'b0, 1);
        @(negedge clk);
        d_in = 1'b1;
        strobe_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({strobe_out, d_out} !== 2'b11) begin
            errors++;
            $display("FAIL reset_premid got s=%b d=%b exp s=1 d=1", strobe_out, d_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({strobe_out, d_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_midframe got s=%b d=%b exp 0 0", strobe_out, d_out);
        end
        strobe_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // Partial frame discarded: next bit is position 1 and gets inverted.
        send_bit(1'b1, 1);
        checks++;
        if ({obs_s, obs_d, obs_s_after} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_restart got s=%b d=%b s_after=%b exp 1 0 0", obs_s, obs_d, obs_s_after);
        end
        // Finish this frame so later tests start aligned.
        for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 1);
    endtask

    task automatic test_frame(input string name, input logic [2:0] ep,
                              input logic [0:6] f, input logic [0:6] want_mask);
        error_pos = ep;
        send_frame(f);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({fok[i], fd[i]} !== {1'b1, fexp[i]}) begin
                errors++;
                $display("FAIL %s bit%0d got ok=%b d=%b exp ok=1 d=%b", name, i + 1, fok[i], fd[i], fexp[i]);
            end
        end
        checks++;
        if ((fd ^ f) !== want_mask) begin
            errors++;
            $display("FAIL %s_mask got %b exp %b", name, fd ^ f, want_mask);
        end
    endtask

    task automatic test_no_injection();
        test_frame("noinj", 3'd0, 7'b0101100, 7'b0000000);
    endtask

    task automatic test_single_injection();
        test_frame("single1", 3'd3, 7'b0101100, 7'b0010000);
        checks++;
        if (fd !== 7'b0111100) begin
            errors++;
            $display("FAIL single_seq got %b exp 0111100", fd);
        end
        test_frame("single2", 3'd3, 7'b0101100, 7'b0010000);
    endtask

    task automatic test_boundaries();
        test_frame("pos7", 3'd7, 7'($urandom), 7'b0000001);
        test_frame("pos1", 3'd1, 7'($urandom), 7'b1000000);
        // Bit 8 wraps to position 1 of the next frame and is inverted again.
        test_frame("wrap", 3'd1, 7'($urandom), 7'b1000000);
    endtask

    task automatic test_mid_change();
        logic [0:6] f1, f2, m1;
        f1 = 7'($urandom);
        f2 = 7'($urandom);
        error_pos = 3'd2;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) error_pos = 3'd5;
            send_bit(f1[i], 1);
            m1[i] = obs_d ^ f1[i];
            checks++;
            if ({obs_s, obs_d} !== {1'b1, exp_d}) begin
                errors++;
                $display("FAIL midchg bit%0d got s=%b d=%b exp s=1 d=%b", i + 1, obs_s, obs_d, exp_d);
            end
        end
        checks++;
        if (m1 !== 7'b0100000) begin
            errors++;
            $display("FAIL midchg_mask1 got %b exp 0100000", m1);
        end
        test_frame("midchg2", 3'd5, f2, 7'b0000100);
    endtask

    task automatic test_long_strobe();
        int pulses;
        logic first_d, e;
        logic d;
        d = 1'($urandom_range(0, 1));
        pulses = 0;
        @(negedge clk);
        d_in = d;
        strobe_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) first_d = d_out;
            if (strobe_out) pulses++;
        end
        @(negedge clk);
        strobe_in = 1'b0;
        @(posedge clk);
        #1;
        if (strobe_out) pulses++;
        model_step(d, int'(error_pos), e);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL long_strobe_pulses got %0d exp 1", pulses);
        end
        checks++;
        if (first_d !== e) begin
            errors++;
            $display("FAIL long_strobe_data got %b exp %b", first_d, e);
        end
    endtask

    task automatic test_random();
        logic d;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) error_pos = 3'($urandom);
            d = 1'($urandom_range(0, 1));
            send_bit(d, $urandom_range(1, 3));
            checks++;
            if ({obs_s, obs_d, obs_s_after} !== {1'b1, exp_d, 1'b0}) begin
                errors++;
                $display("FAIL random%0d got s=%b d=%b s_after=%b exp 1 %b 0", i, obs_s, obs_d, obs_s_after, exp_d);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic d;
        do_reset();
        error_pos = 3'd6;
        for (int i = 0; i < 10; i++) begin
            d = 1'($urandom_range(0, 1));
            send_bit(d, 1);
            checks++;
            if ({obs_s5, obs_d5} !== {1'b1, d}) begin
                errors++;
                $display("FAIL oor5_bit%0d got s=%b d=%b exp s=1 d=%b", i, obs_s5, obs_d5, d);
            end
            checks++;
            if (obs_d !== exp_d) begin
                errors++;
                $display("FAIL oor7_bit%0d got d=%b exp %b", i, obs_d, exp_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_injection();
        test_single_injection();
        test_boundaries();
        test_mid_change();
        test_long_strobe();
        test_random();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule : tb_error_inject_serial
